// File: rtl/fir_seq.sv
// fir_seq: FIR sequencer in front of a 16-bit data memory.
// Each accepted sample is written into a circular buffer. TAPS delayed samples
// are then multiplied against the coefficient table and accumulated. One
// rounded, saturated Q15 result is returned per sample over a valid/ready pair.
//
// state | meaning
// CLEAR | zero the circular buffer, one word per cycle
// IDLE  | waiting for an input sample
// WRITE | store the latched sample at BASE+wp
// MAC   | accumulate h[k] * x[wp-k] for k = 0..TAPS-1
// DONE  | hold the result until downstream takes it
module fir_seq #(
  parameter int TAPS    = 8,
  parameter int BUF_LEN = 16,
  parameter int BASE    = 0,
  parameter int ACC_W   = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [15:0] sample_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        dm_en,
  output logic [7:0]  dm_addr,
  output logic [15:0] dm_in,
  input  logic [15:0] dm_out,
  output logic [7:0]  coef_addr,
  input  logic [15:0] coef_data
);

  localparam int AW = (BUF_LEN > 2) ? $clog2(BUF_LEN) : 1;
  localparam logic [7:0]    BASE_A   = 8'(BASE);
  localparam logic [7:0]    LAST_K   = 8'(TAPS - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(BUF_LEN - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-32768);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WRITE, S_MAC, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic [AW-1:0]            wp_q, wp_d;
  logic [7:0]               k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [15:0]              smp_q, smp_d;
  logic                     out_valid_q, out_valid_d;
  logic [15:0]              out_data_q, out_data_d;

  logic signed [15:0]       dm_s, coef_s;
  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W:0]    rnd;
  logic signed [ACC_W:0]    shr;
  logic [15:0]              sat_val;
  logic [AW-1:0]            rd_ptr;

  assign dm_s    = $signed(dm_out);
  assign coef_s  = $signed(coef_data);
  // Full 32-bit product; operands are sign-extended first so the low 32 bits are exact.
  assign prod    = 32'(dm_s) * 32'(coef_s);
  assign acc_sum = acc_q + $signed({{(ACC_W-32){prod[31]}}, prod});
  // One extra bit of headroom so the rounding constant can never wrap the sum.
  assign rnd     = $signed({acc_sum[ACC_W-1], acc_sum}) + (ACC_W+1)'(16384);
  assign shr     = rnd >>> 15;
  assign rd_ptr  = wp_q - k_q[AW-1:0];

  // Clamp the rounded accumulator into the Q15 range.
  always_comb begin
    sat_val = shr[15:0];
    if (shr > SAT_MAX)      sat_val = 16'h7FFF;
    else if (shr < SAT_MIN) sat_val = 16'h8000;
  end

  // Next-state and output decode; outputs default to the idle pattern.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wp_d         = wp_q;
    k_d          = k_q;
    acc_d        = acc_q;
    smp_d        = smp_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    sample_ready = 1'b0;
    dm_en        = 1'b0;
    dm_addr      = BASE_A + 8'(wp_q);
    dm_in        = 16'h0000;
    coef_addr    = 8'h00;
    case (state_q)
      S_CLEAR: begin
        dm_en   = 1'b1;
        dm_addr = BASE_A + 8'(idx_q);
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = S_IDLE;
      end
      S_IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          smp_d   = sample_data;
          acc_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        dm_en   = 1'b1;
        dm_in   = smp_q;
        k_d     = 8'h00;
        state_d = S_MAC;
      end
      S_MAC: begin
        dm_addr   = BASE_A + 8'(rd_ptr);
        coef_addr = k_q;
        acc_d     = acc_sum;
        k_d       = k_q + 8'h01;
        if (k_q == LAST_K) begin
          out_valid_d = 1'b1;
          out_data_d  = sat_val;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          wp_d        = wp_q + 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // State registers; reset restarts the buffer clear and drops any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      idx_q       <= '0;
      wp_q        <= '0;
      k_q         <= 8'h00;
      acc_q       <= '0;
      smp_q       <= 16'h0000;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wp_q        <= wp_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      smp_q       <= smp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_seq.sv
// tb_fir_seq: randomized checks of fir_seq against a direct-form FIR model.
module tb_fir_seq;
  localparam int TAPS    = 8;
  localparam int BUF_LEN = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [15:0] sample_data = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        dm_en;
  logic [7:0]  dm_addr;
  logic [15:0] dm_in;
  logic [15:0] dm_out;
  logic [7:0]  coef_addr;
  logic [15:0] coef_data;

  always #5 clk = ~clk;

  fir_seq #(.TAPS(TAPS), .BUF_LEN(BUF_LEN), .BASE(0), .ACC_W(40)) dut (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dm_en(dm_en), .dm_addr(dm_addr), .dm_in(dm_in), .dm_out(dm_out),
    .coef_addr(coef_addr), .coef_data(coef_data)
  );

  // Data memory and coefficient table seen by the DUT.
  logic [15:0] dmem [256];
  logic [15:0] coef [TAPS];
  assign dm_out = dmem[dm_addr];
  always_ff @(posedge clk) if (dm_en) dmem[dm_addr] <= dm_in;
  always_comb coef_data = (coef_addr < 8'(TAPS)) ? coef[coef_addr[2:0]] : 16'h0000;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  logic signed [15:0] hist [$];
  logic [7:0] wr_seen;
  logic [7:0] mac_seen [TAPS];
  int acc_cyc;

  // y[n] = sat(round(sum_k h[k] * x[n-k])), buffer zeroed at reset.
  function automatic logic [15:0] model_out();
    longint s = 0;
    int n = hist.size() - 1;
    for (int k = 0; k < TAPS; k++)
      if (n - k >= 0) s += longint'($signed(coef[k])) * longint'(hist[n-k]);
    s = (s + 16384) >>> 15;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
  endtask

  // Offer one sample and wait for its result; records write and MAC addresses.
  task automatic send(input logic [15:0] x, output logic [15:0] y, output int lat, output bit to);
    int w = 0;
    to = 1'b0; y = 16'h0; lat = 0;
    while (sample_ready !== 1'b1) begin
      if (w >= 200) begin to = 1'b1; return; end
      @(negedge clk); w++;
    end
    sample_valid = 1'b1; sample_data = x; acc_cyc = cyc;
    @(negedge clk);
    sample_valid = 1'b0;
    hist.push_back(x);
    while (1) begin
      if (lat == 0) wr_seen = (dm_en === 1'b1) ? dm_addr : 8'hFF;
      else if (lat <= TAPS) mac_seen[lat-1] = dm_addr;
      if (out_valid === 1'b1) break;
      if (lat >= 100) begin to = 1'b1; return; end
      @(negedge clk); lat++;
    end
    y = out_data;
  endtask

  task automatic consume(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic push(input logic [15:0] x, input int hold, output logic [15:0] y, output int lat, output bit to);
    send(x, y, lat, to);
    if (!to) consume(hold);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < BUF_LEN; i++) begin
      total++;
      if ({dm_en, dm_in, dm_addr, sample_ready, out_valid} !== {1'b1, 16'h0, 8'(i), 1'b0, 1'b0}) begin
        $display("FAIL reset_clear cyc%0d: got en=%b in=%h addr=%0d rdy=%b ov=%b, want en=1 in=0 addr=%0d rdy=0 ov=0",
                 i, dm_en, dm_in, dm_addr, sample_ready, out_valid, i);
      end else passed++;
      @(negedge clk);
    end
    total++;
    if ({sample_ready, dm_en, out_valid} !== 3'b100)
      $display("FAIL reset_ready: got rdy=%b en=%b ov=%b, want 1 0 0", sample_ready, dm_en, out_valid);
    else passed++;
  endtask

  task automatic test_impulse();
    logic [15:0] y, exp;
    int lat;
    bit to;
    for (int k = 0; k < TAPS; k++) coef[k] = 16'h4000;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push((i == 0) ? 16'h4000 : 16'h0000, 0, y, lat, to);
      exp = (i < 8) ? 16'h2000 : 16'h0000;
      total++;
      if (to || y !== exp) $display("FAIL impulse_out%0d: got %h (timeout=%0d), want %h", i + 1, y, to, exp);
      else passed++;
      total++;
      if (lat !== TAPS + 1) $display("FAIL impulse_latency%0d: got %0d, want %0d", i + 1, lat, TAPS + 1);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    logic [15:0] y;
    int lat;
    bit to;
    for (int k = 0; k < TAPS; k++) coef[k] = 16'h7FFF;
    do_reset();
    push(16'h7FFF, 0, y, lat, to);
    total++;
    if (to || y !== model_out()) $display("FAIL sat_pos_first: got %h, want %h", y, model_out());
    else passed++;
    push(16'h7FFF, 0, y, lat, to);
    total++;
    if (to || y !== 16'h7FFF) $display("FAIL sat_pos: got %h, want 7fff", y);
    else passed++;
    do_reset();
    push(16'h8000, 0, y, lat, to);
    push(16'h8000, 0, y, lat, to);
    total++;
    if (to || y !== 16'h8000) $display("FAIL sat_neg: got %h, want 8000", y);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [15:0] y, y0;
    int lat;
    bit to;
    for (int k = 0; k < TAPS; k++) coef[k] = 16'($urandom);
    do_reset();
    for (int i = 0; i < 3; i++) push(16'($urandom), 0, y, lat, to);
    send(16'($urandom), y0, lat, to);
    total++;
    if (to || y0 !== model_out()) $display("FAIL bp_value: got %h, want %h", y0, model_out());
    else passed++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_data, sample_ready, dm_en, dm_addr} !== {1'b1, y0, 1'b0, 1'b0, 8'd3})
        $display("FAIL bp_hold%0d: got ov=%b data=%h rdy=%b en=%b addr=%0d, want 1 %h 0 0 3",
                 c, out_valid, out_data, sample_ready, dm_en, dm_addr, y0);
      else passed++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({out_valid, sample_ready, dm_addr} !== {1'b0, 1'b1, 8'd4})
      $display("FAIL bp_release: got ov=%b rdy=%b addr=%0d, want 0 1 4", out_valid, sample_ready, dm_addr);
    else passed++;
    @(negedge clk);
    total++;
    if ({out_valid, sample_ready, dm_addr} !== {1'b0, 1'b1, 8'd4})
      $display("FAIL bp_single_transfer: got ov=%b rdy=%b addr=%0d, want 0 1 4", out_valid, sample_ready, dm_addr);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [15:0] y;
    logic [7:0] exp_a;
    int lat, bad;
    bit to;
    for (int k = 0; k < TAPS; k++) coef[k] = 16'($urandom);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push(16'(i * 1500 - 9000), 0, y, lat, to);
      total++;
      if (to || y !== model_out()) $display("FAIL wrap_out%0d: got %h, want %h", i + 1, y, model_out());
      else passed++;
      total++;
      if (wr_seen !== 8'(i % BUF_LEN)) $display("FAIL wrap_wr_addr%0d: got %0d, want %0d", i + 1, wr_seen, i % BUF_LEN);
      else passed++;
      bad = 0;
      for (int k = 0; k < TAPS; k++) begin
        exp_a = 8'((i - k + 4 * BUF_LEN) % BUF_LEN);
        if (mac_seen[k] !== exp_a) bad++;
      end
      total++;
      if (bad != 0) $display("FAIL wrap_mac_addr%0d: %0d reads wrong, k0 got %0d want %0d, k7 got %0d want %0d",
                             i + 1, bad, mac_seen[0], i % BUF_LEN, mac_seen[TAPS-1], (i - 7 + 4 * BUF_LEN) % BUF_LEN);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] y;
    int lat, hold, prev_acc, prev_hold;
    bit to;
    for (int k = 0; k < TAPS; k++) coef[k] = 16'($urandom);
    do_reset();
    prev_hold = -1; prev_acc = 0;
    for (int i = 0; i < 25; i++) begin
      hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      send(16'($urandom), y, lat, to);
      total++;
      if (to || y !== model_out() || lat !== TAPS + 1)
        $display("FAIL b2b_out%0d: got %h lat %0d, want %h lat %0d", i, y, lat, model_out(), TAPS + 1);
      else passed++;
      if (prev_hold == 0) begin
        total++;
        if (acc_cyc - prev_acc !== TAPS + 3)
          $display("FAIL b2b_period%0d: got %0d, want %0d", i, acc_cyc - prev_acc, TAPS + 3);
        else passed++;
      end
      prev_acc = acc_cyc; prev_hold = hold;
      if (!to) consume(hold);
    end
  endtask

  task automatic test_reset_mid_mac();
    logic [15:0] y;
    int lat, w;
    bit to, seen_ov;
    for (int k = 0; k < TAPS; k++) coef[k] = 16'($urandom);
    do_reset();
    push(16'($urandom), 0, y, lat, to);
    w = 0;
    while (sample_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    sample_valid = 1'b1; sample_data = 16'h7123;
    @(negedge clk);
    sample_valid = 1'b0;
    w = 0;
    while (coef_addr !== 8'd3 && w < 20) begin @(negedge clk); w++; end
    total++;
    if (coef_addr !== 8'd3) $display("FAIL midmac_reach_k3: got coef_addr %0d, want 3", coef_addr);
    else passed++;
    do_reset();
    total++;
    if ({dm_en, dm_addr, sample_ready, out_valid} !== {1'b1, 8'd0, 1'b0, 1'b0})
      $display("FAIL midmac_clear: got en=%b addr=%0d rdy=%b ov=%b, want 1 0 0 0", dm_en, dm_addr, sample_ready, out_valid);
    else passed++;
    w = 1; seen_ov = 1'b0;
    @(negedge clk);
    while (sample_ready !== 1'b1 && w < 40) begin
      if (out_valid === 1'b1) seen_ov = 1'b1;
      @(negedge clk); w++;
    end
    total++;
    if (seen_ov || w !== BUF_LEN) $display("FAIL midmac_recover: got out_valid_seen=%0d clear_len=%0d, want 0 %0d", seen_ov, w, BUF_LEN);
    else passed++;
    push(16'h1234, 0, y, lat, to);
    total++;
    if (to || wr_seen !== 8'd0 || y !== model_out())
      $display("FAIL midmac_next: got addr %0d out %h, want addr 0 out %h", wr_seen, y, model_out());
    else passed++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fir_seq.md
Name: fir_seq

Overview:
- FIR filter sequencer that sits directly upstream of the 16-bit data memory and drives its clk-domain write port and combinational read port.
- Stores each incoming sample in a circular buffer region of data memory.
- Walks TAPS delayed samples against a coefficient table, accumulating signed Q15 products.
- Emits one saturated Q15 output per input sample over a valid/ready handshake.

Parameters:
- TAPS, 8, number of filter taps; 1 <= TAPS <= BUF_LEN.
- BUF_LEN, 16, circular buffer length in words; power of two, 2..128.
- BASE, 0, first data-memory word address of the buffer; BASE+BUF_LEN <= 144.
- ACC_W, 40, accumulator width in bits, signed.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  input sample offered.
- sample_ready  out  1  block accepts a sample this cycle.
- sample_data  in  16  signed Q15 input sample.
- out_valid  out  1  filtered result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  16  signed Q15 filtered result.
- dm_en  out  1  data-memory write enable.
- dm_addr  out  8  data-memory address, used for both read and write.
- dm_in  out  16  data-memory write data.
- dm_out  in  16  data-memory read data; combinational from dm_addr in the same cycle.
- coef_addr  out  8  coefficient index k.
- coef_data  in  16  signed Q15 coefficient h[k]; combinational from coef_addr in the same cycle.

Behaviour:
- States: CLEAR, IDLE, WRITE, MAC, DONE.
- Reset (synchronous, any state, including mid-MAC or DONE):
  - state=CLEAR, idx=0, wp=0, acc=0.
  - out_valid=0, out_data=0.
  - Any in-flight computation is discarded.
- CLEAR:
  - dm_en=1, dm_addr=BASE+idx, dm_in=0, sample_ready=0.
  - idx increments each cycle; after idx=BUF_LEN-1, go to IDLE.
  - Takes exactly BUF_LEN cycles.
- IDLE:
  - sample_ready=1, dm_en=0.
  - sample_valid=1 at an edge: latch sample_data, clear acc, go to WRITE.
- WRITE (1 cycle):
  - dm_en=1, dm_addr=BASE+wp, dm_in=latched sample, sample_ready=0.
  - Next state MAC with k=0.
- MAC (TAPS cycles, k=0..TAPS-1):
  - dm_en=0.
  - dm_addr=BASE+((wp-k) mod BUF_LEN), with wrap via low log2(BUF_LEN) bits.
  - coef_addr=k.
  - acc += sign-extend(signed(dm_out) * signed(coef_data)), a full 32-bit product, no intermediate saturation.
  - The k=0 read returns the sample written in WRITE.
  - After k=TAPS-1, go to DONE.
- DONE:
  - out_valid=1.
  - out_data = clamp((acc + 16384) >>> 15, -32768, 32767), registered on entry and stable while out_valid=1.
  - Edge with out_ready=1: out_valid=0, wp=(wp+1) mod BUF_LEN, go to IDLE.
  - out_ready=0: hold all outputs, wp, and acc unchanged.
- Latency:
  - out_valid rises TAPS+1 cycles after the accepting edge.
  - Minimum sample period is TAPS+3 cycles with out_ready tied high.
- Outputs outside the states that drive them:
  - dm_in=0, dm_addr=BASE+wp, coef_addr=0 when not otherwise driven.
  - dm_en=1 only in CLEAR and WRITE.
- Simultaneous events:
  - A sample is never accepted in the cycle a result is consumed; sample_ready is IDLE-only.
  - reset has priority over every handshake.

Test Plan:
- Reset clear: pulse reset 1 cycle -> 16 consecutive cycles of dm_en=1, dm_in=0, dm_addr=0..15, sample_ready=0; sample_ready=1 on the 17th cycle; out_valid=0 throughout.
- Impulse response: all coef=0x4000; feed 0x4000 then 9 samples of 0x0000, out_ready=1 -> outputs 1..8 = 0x2000, outputs 9..10 = 0x0000; out_valid rises 9 cycles after each accept.
- Saturation:
  - coef all 0x7FFF; samples 0x7FFF,0x7FFF -> second output 0x7FFF.
  - After re-reset, samples 0x8000,0x8000 -> second output 0x8000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, out_data stable, sample_ready=0, wp unchanged; release -> exactly one transfer, then IDLE.
- Wrap-around:
  - Feed 20 ramp samples; sample 17 is written at dm_addr=0.
  - With wp=1, MAC reads dm_addr 1,0,15,14,13,12,11,10.
  - Outputs match a software FIR model.
- Reset mid-MAC: assert reset at MAC k=3 -> next cycle state CLEAR, out_valid=0, wp=0; no output is produced for the aborted sample.
